control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that sequences the 32-bit bus datapath (R0–R15, PC, IR, MAR, MDR, Y, Z, HI/LO) through fetch and execute.
- Drives every register-in, bus-out, ALU-op and memory strobe from a registered T-state machine plus the latched IR.
- Waits on a memory ack handshake for each memory access.
- Counts retired instructions and flags faults.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before entering FAULT (legal range 1–255).
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- run  in  1  start pulse; sampled in IDLE only.
- ir  in  32  IR contents: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- mem_ack  in  1  memory read data valid or write done.
- rin  out  16  one-hot register load (bit n = Rnin).
- rout  out  16  one-hot register drive (bit n = Rnout).
- PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout  out  1 each  datapath strobes.
- ALU_opcode  out  5  ALU operation.
- mem_rd, mem_wr  out  1 each  memory request, held until ack.
- busy, halted, fault  out  1 each  status.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- State register updates on posedge clk. Outputs are Moore: a combinational function of state and ir only.
- clr (any state, including mid-wait): state=IDLE, wait counter=0, instr_count=0, halted=0, fault=0. Every strobe and request drops to 0 the same edge. ALU_opcode=5'h00.
- States: IDLE, T0–T7, HALTED, FAULT.
- IDLE:
  - run=1 -> T0.
  - busy=0.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: mem_rd, MDRread, MDRin. Stay in T1 until mem_ack=1.
  - T2: MDRout, IRin.
- T3 decode uses ir latched by T2.
- Opcode classes:
  - 00–08: R-type ALU.
  - 09–0B: immediate add/and/or.
  - 0C: mul. 0D: div.
  - 0E: ld. 0F: st.
  - 18: nop. 1B: halt.
  - Anything else: illegal.
- R-type:
  - T3: rout[rb], Yin.
  - T4: rout[rc], Zin, ALU_opcode=opcode.
  - T5: ZLOout, rin[ra]. Retire.
- Immediate:
  - Same as R-type, but T4 uses Cout instead of rout[rc].
  - ALU_opcode = ADD/AND/OR code from the package.
- mul/div:
  - T3: rout[ra], Yin.
  - T4: rout[rb], Zin.
  - T5: ZLOout, Loin.
  - T6: ZHIout, HIin. Retire.
- ld:
  - T3: rout[rb], Yin.
  - T4: Cout, Zin, ALU add.
  - T5: ZLOout, MARin.
  - T6: mem_rd, MDRread, MDRin; wait for ack.
  - T7: MDRout, rin[ra]. Retire.
- st:
  - T3–T5 as ld.
  - T6: rout[ra], MDRin with MDRread=0.
  - T7: mem_wr; wait for ack. Retire.
- nop: retires at T3.
- Retire:
  - instr_count += 1 on the retiring edge; wraps at 2^COUNT_W.
  - Next state = T0 (continuous run).
- halt: T3 -> HALTED. halted=1, not counted. Exit only by clr.
- Illegal opcode: T3 -> FAULT. fault=1, no strobes. Exit only by clr.
- Memory wait:
  - Counter increments each waiting cycle and clears on ack.
  - Reaching MEM_TIMEOUT without ack -> FAULT, with the request dropped.
  - mem_ack outside a wait state is ignored.
- run while busy: ignored.
- busy=1 in T0–T7.
- rin/rout are never multi-hot. At most one bus driver is asserted per cycle.

Optional Feature:
- CTRL_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - After each retire the FSM goes to IDLE instead of T0.
  - run or step in IDLE starts the next fetch.
- When undefined: no step port; retire goes directly to T0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants and opcode class ranges;
  - state encoding enum (4 bits);
  - ALU op codes (ADD, AND, OR);
  - IR field bit positions.
- Sub-module ctrl_decode (combinational): maps state and ir to the strobe vector and ALU_opcode.
- FSM, wait counter and instr_count stay in control_sequencer.

Test Plan:
- R-type: ir = add, ra=3, rb=1, rc=2. run, ack 1 cycle after mem_rd.
  -> T0..T5 sequence; rin=16'h0008 in T5; instr_count=1; back to T0.
- ld: ir = ld, ra=4, rb=5. mem_ack delayed 3 cycles in T6.
  -> mem_rd held 3 cycles; T7 asserts MDRout with rin=16'h0010.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted in T1.
  -> fault=1 after 4 wait cycles; mem_rd=0; strobes idle.
- Halt and illegal: opcode 1B -> halted=1, count unchanged. Opcode 1F -> fault=1. clr -> IDLE, all outputs 0.
- Mid-operation reset: clr asserted in T4 of a mul.
  -> next cycle IDLE; Zin=0; instr_count=0; HIin/Loin never asserted.
- With CTRL_STEP_EN: two nops, step pulses 5 cycles apart.
  -> each instruction retires then waits in IDLE; instr_count steps 1 then 2.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types for the hardwired control sequencer: state encoding, opcode map,
// ALU codes, IR field positions and the per-cycle control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_T7     = 4'd8,
        ST_HALTED = 4'd9,
        ST_FAULT  = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;

    localparam logic [4:0] OP_RTYPE_LAST = 5'h08;
    localparam logic [4:0] OP_ANDI       = 5'h0A;
    localparam logic [4:0] OP_ORI        = 5'h0B;
    localparam logic [4:0] OP_MUL        = 5'h0C;
    localparam logic [4:0] OP_DIV        = 5'h0D;
    localparam logic [4:0] OP_LD         = 5'h0E;
    localparam logic [4:0] OP_ST         = 5'h0F;
    localparam logic [4:0] OP_NOP        = 5'h18;
    localparam logic [4:0] OP_HALT       = 5'h1B;

    localparam logic [4:0] ALU_ADD = 5'h01;
    localparam logic [4:0] ALU_AND = 5'h02;
    localparam logic [4:0] ALU_OR  = 5'h03;

    typedef struct packed {
        logic        pc_out;
        logic        inc_pc;
        logic        mar_in;
        logic        mdr_in;
        logic        mdr_read;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        z_in;
        logic        zlo_out;
        logic        zhi_out;
        logic        hi_in;
        logic        lo_in;
        logic        c_out;
        logic        mem_rd;
        logic        mem_wr;
        logic [4:0]  alu_op;
        logic [15:0] rin;
        logic [15:0] rout;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [4:0] opc);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        if (opc <= OP_RTYPE_LAST)                cls = CLS_RTYPE;
        else if (opc <= OP_ORI)                  cls = CLS_IMM;
        else if (opc == OP_MUL || opc == OP_DIV) cls = CLS_MULDIV;
        else if (opc == OP_LD)                   cls = CLS_LD;
        else if (opc == OP_ST)                   cls = CLS_ST;
        else if (opc == OP_NOP)                  cls = CLS_NOP;
        else if (opc == OP_HALT)                 cls = CLS_HALT;
        return cls;
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [4:0] opc);
        logic [4:0] op;
        case (opc)
            OP_ANDI: op = ALU_AND;
            OP_ORI:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath control bus between the sequencer (master) and the datapath (slave).
// Handshake: mem_rd/mem_wr are held high until a cycle in which mem_ack=1 is sampled; that edge completes the access.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ack;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin;
    logic        Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout;
    logic [4:0]  ALU_opcode;
    logic        mem_rd, mem_wr;

    modport master (
        input  ir, mem_ack,
        output rin, rout, PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout, ALU_opcode, mem_rd, mem_wr
    );

    modport slave (
        output ir, mem_ack,
        input  rin, rout, PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout, ALU_opcode, mem_rd, mem_wr
    );
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational decode: T-state plus IR to the full control word (Moore outputs).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic [31:0] ir_i,
    output op_class_t   cls_o,
    output ctrl_t       ctrl_o
);
    logic [4:0]  opc;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        unused_ir;

    assign opc       = ir_i[IR_OPC_LSB +: 5];
    assign ra_oh     = reg_onehot(ir_i[IR_RA_LSB +: 4]);
    assign rb_oh     = reg_onehot(ir_i[IR_RB_LSB +: 4]);
    assign rc_oh     = reg_onehot(ir_i[IR_RC_LSB +: 4]);
    assign unused_ir = ^ir_i[IR_RC_LSB-1:0];
    assign cls_o     = op_class(opc);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_T0: begin ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1; ctrl_o.inc_pc = 1'b1; end
            ST_T1: begin ctrl_o.mem_rd = 1'b1; ctrl_o.mdr_read = 1'b1; ctrl_o.mdr_in = 1'b1; end
            ST_T2: begin ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1; end
            ST_T3: begin
                case (cls_o)
                    CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST: begin ctrl_o.rout = rb_oh; ctrl_o.y_in = 1'b1; end
                    CLS_MULDIV: begin ctrl_o.rout = ra_oh; ctrl_o.y_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                ctrl_o.z_in = 1'b1;
                case (cls_o)
                    CLS_RTYPE:    begin ctrl_o.rout = rc_oh; ctrl_o.alu_op = opc; end
                    CLS_IMM:      begin ctrl_o.c_out = 1'b1; ctrl_o.alu_op = imm_alu_op(opc); end
                    CLS_MULDIV:   begin ctrl_o.rout = rb_oh; ctrl_o.alu_op = opc; end
                    CLS_LD, CLS_ST: begin ctrl_o.c_out = 1'b1; ctrl_o.alu_op = ALU_ADD; end
                    default:      ctrl_o.z_in = 1'b0;
                endcase
            end
            ST_T5: begin
                ctrl_o.zlo_out = 1'b1;
                case (cls_o)
                    CLS_RTYPE, CLS_IMM: ctrl_o.rin = ra_oh;
                    CLS_MULDIV:         ctrl_o.lo_in = 1'b1;
                    CLS_LD, CLS_ST:     ctrl_o.mar_in = 1'b1;
                    default:            ctrl_o.zlo_out = 1'b0;
                endcase
            end
            ST_T6: begin
                case (cls_o)
                    CLS_MULDIV: begin ctrl_o.zhi_out = 1'b1; ctrl_o.hi_in = 1'b1; end
                    CLS_LD: begin ctrl_o.mem_rd = 1'b1; ctrl_o.mdr_read = 1'b1; ctrl_o.mdr_in = 1'b1; end
                    CLS_ST: begin ctrl_o.rout = ra_oh; ctrl_o.mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls_o)
                    CLS_LD:  begin ctrl_o.mdr_out = 1'b1; ctrl_o.rin = ra_oh; end
                    CLS_ST:  ctrl_o.mem_wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit with memory-ack wait/timeout and retire counter.
// Build option CTRL_STEP_EN: adds a step input and parks in IDLE after every retire.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
`ifdef CTRL_STEP_EN
    input  logic               step,
`endif
    control_sequencer_if.master bus,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count,
    output state_t             state_dbg
);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef CTRL_STEP_EN
    localparam state_t RETIRE_NEXT = ST_IDLE;
    logic start;
    assign start = run | step;
`else
    localparam state_t RETIRE_NEXT = ST_T0;
    logic start;
    assign start = run;
`endif

    state_t             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [COUNT_W-1:0] count_q, count_d;
    op_class_t          cls;
    ctrl_t              ctrl;
    logic               in_wait, mem_done, mem_timeout, retire;

    ctrl_decode u_decode (
        .state_i (state_q),
        .ir_i    (bus.ir),
        .cls_o   (cls),
        .ctrl_o  (ctrl)
    );

    // Wait states are exactly the cycles in which a memory request is driven.
    always_comb begin
        in_wait = 1'b0;
        case (state_q)
            ST_T1:   in_wait = 1'b1;
            ST_T6:   in_wait = (cls == CLS_LD);
            ST_T7:   in_wait = (cls == CLS_ST);
            default: in_wait = 1'b0;
        endcase
    end

    assign mem_done    = in_wait & bus.mem_ack;
    assign mem_timeout = in_wait & ~bus.mem_ack & (wait_q == WAIT_LAST);
    assign wait_d      = (in_wait && !bus.mem_ack && !mem_timeout) ? wait_q + 8'd1 : 8'd0;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1: begin
                if (mem_done)         state_d = ST_T2;
                else if (mem_timeout) state_d = ST_FAULT;
            end
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_NOP:     retire  = 1'b1;
                    CLS_HALT:    state_d = ST_HALTED;
                    CLS_ILLEGAL: state_d = ST_FAULT;
                    default:     state_d = ST_T4;
                endcase
            end
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (cls == CLS_RTYPE || cls == CLS_IMM) retire  = 1'b1;
                else                                    state_d = ST_T6;
            end
            ST_T6: begin
                case (cls)
                    CLS_MULDIV: retire = 1'b1;
                    CLS_LD: begin
                        if (mem_done)         state_d = ST_T7;
                        else if (mem_timeout) state_d = ST_FAULT;
                    end
                    CLS_ST:  state_d = ST_T7;
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_T7: begin
                if (cls == CLS_LD)      retire  = 1'b1;
                else if (cls != CLS_ST) state_d = ST_FAULT;
                else if (mem_done)      retire  = 1'b1;
                else if (mem_timeout)   state_d = ST_FAULT;
            end
            ST_HALTED, ST_FAULT: state_d = state_q;
            default: state_d = ST_FAULT;
        endcase
        if (retire) begin
            state_d = RETIRE_NEXT;
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    assign bus.PCout      = ctrl.pc_out;
    assign bus.IncPC      = ctrl.inc_pc;
    assign bus.MARin      = ctrl.mar_in;
    assign bus.MDRin      = ctrl.mdr_in;
    assign bus.MDRread    = ctrl.mdr_read;
    assign bus.MDRout     = ctrl.mdr_out;
    assign bus.IRin       = ctrl.ir_in;
    assign bus.Yin        = ctrl.y_in;
    assign bus.Zin        = ctrl.z_in;
    assign bus.ZLOout     = ctrl.zlo_out;
    assign bus.ZHIout     = ctrl.zhi_out;
    assign bus.HIin       = ctrl.hi_in;
    assign bus.Loin       = ctrl.lo_in;
    assign bus.Cout       = ctrl.c_out;
    assign bus.ALU_opcode = ctrl.alu_op;
    assign bus.mem_rd     = ctrl.mem_rd;
    assign bus.mem_wr     = ctrl.mem_wr;
    assign bus.rin        = ctrl.rin;
    assign bus.rout       = ctrl.rout;

    assign busy        = (state_q >= ST_T0) && (state_q <= ST_T7);
    assign halted      = (state_q == ST_HALTED);
    assign fault       = (state_q == ST_FAULT);
    assign instr_count = count_q;
    assign state_dbg   = state_q;
endmodule
